// File: rtl/io_input_debounce.sv
// io_input_debounce: synchronizes and debounces the board switch banks and the
// push key ahead of the I/O input register bank, and emits a one-cycle strobe on
// each debounced key press.
// Optional feature macro: KEY_TOGGLE_EN. When it is defined, in_port2 becomes a
// toggle flop that flips on every key press. When it is undefined, in_port2 is
// the debounced key level.
//
// Timing: when a raw input settles before edge k, its synchronized sample is
// valid after edge k+1. The output group updates on edge k+1+DEBOUNCE_CYCLES.
// The edge on which a new candidate value is first seen counts as the first of
// the DEBOUNCE_CYCLES stable samples. Any change in the sample restarts that
// count. A sample that matches the current output clears the count.
module io_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       io_clk,
    input  logic       reset,
    input  logic [3:0] sw0_raw,
    input  logic [3:0] sw1_raw,
    input  logic       key_raw,
    output logic [3:0] in_port0,
    output logic [3:0] in_port1,
    output logic       in_port2,
    output logic       key_rise
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef struct packed {
        logic [3:0]       val;
        logic [CNT_W-1:0] cnt;
    } grp_t;

    // Next state of one 4-bit debounce group. The whole vector is treated as a unit.
    function automatic grp_t grp_next(input logic [3:0]       sample,
                                      input logic [3:0]       prev,
                                      input logic [3:0]       cur,
                                      input logic [CNT_W-1:0] cnt);
        grp_t nxt;
        nxt.val = cur;
        nxt.cnt = CNT_ZERO;
        if (sample == cur) begin
            nxt.cnt = CNT_ZERO;
        end else if (sample != prev) begin
            if (LAST_CNT == CNT_ZERO) begin
                nxt.val = sample;
                nxt.cnt = CNT_ZERO;
            end else begin
                nxt.cnt = CNT_ONE;
            end
        end else if (cnt == LAST_CNT) begin
            nxt.val = sample;
            nxt.cnt = CNT_ZERO;
        end else begin
            nxt.cnt = cnt + CNT_ONE;
        end
        return nxt;
    endfunction

    logic [8:0]       sync1_r;
    logic [8:0]       sync2_r;
    logic [3:0]       sw0_prev_r;
    logic [3:0]       sw0_out_r;
    logic [CNT_W-1:0] sw0_cnt_r;
    logic [3:0]       sw1_prev_r;
    logic [3:0]       sw1_out_r;
    logic [CNT_W-1:0] sw1_cnt_r;
    logic             key_prev_r;
    logic             key_out_r;
    logic [CNT_W-1:0] key_cnt_r;
    logic             key_rise_r;
    grp_t             sw0_nxt_s;
    grp_t             sw1_nxt_s;
    logic             key_out_nxt_s;
    logic [CNT_W-1:0] key_cnt_nxt_s;
    logic             key_press_s;

    // Two-flop synchronizer for all raw inputs: {key, sw1, sw0}.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 9'h000;
            sync2_r <= 9'h000;
        end else begin
            sync1_r <= {key_raw, sw1_raw, sw0_raw};
            sync2_r <= sync1_r;
        end
    end

    // Next state of the two switch groups.
    always_comb begin
        sw0_nxt_s = grp_next(sync2_r[3:0], sw0_prev_r, sw0_out_r, sw0_cnt_r);
        sw1_nxt_s = grp_next(sync2_r[7:4], sw1_prev_r, sw1_out_r, sw1_cnt_r);
    end

    // Next state of the 1-bit key group. It follows the same rules as the switch groups.
    always_comb begin
        key_out_nxt_s = key_out_r;
        key_cnt_nxt_s = CNT_ZERO;
        if (sync2_r[8] == key_out_r) begin
            key_cnt_nxt_s = CNT_ZERO;
        end else if (sync2_r[8] != key_prev_r) begin
            if (LAST_CNT == CNT_ZERO) begin
                key_out_nxt_s = sync2_r[8];
                key_cnt_nxt_s = CNT_ZERO;
            end else begin
                key_cnt_nxt_s = CNT_ONE;
            end
        end else if (key_cnt_r == LAST_CNT) begin
            key_out_nxt_s = sync2_r[8];
            key_cnt_nxt_s = CNT_ZERO;
        end else begin
            key_cnt_nxt_s = key_cnt_r + CNT_ONE;
        end
    end

    // A key press is the edge on which the debounced key goes from 0 to 1.
    assign key_press_s = key_out_nxt_s & ~key_out_r;

    // Debounce group state registers and the registered key press strobe.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            sw0_prev_r <= 4'h0;
            sw0_out_r  <= 4'h0;
            sw0_cnt_r  <= CNT_ZERO;
            sw1_prev_r <= 4'h0;
            sw1_out_r  <= 4'h0;
            sw1_cnt_r  <= CNT_ZERO;
            key_prev_r <= 1'b0;
            key_out_r  <= 1'b0;
            key_cnt_r  <= CNT_ZERO;
            key_rise_r <= 1'b0;
        end else begin
            sw0_prev_r <= sync2_r[3:0];
            sw0_out_r  <= sw0_nxt_s.val;
            sw0_cnt_r  <= sw0_nxt_s.cnt;
            sw1_prev_r <= sync2_r[7:4];
            sw1_out_r  <= sw1_nxt_s.val;
            sw1_cnt_r  <= sw1_nxt_s.cnt;
            key_prev_r <= sync2_r[8];
            key_out_r  <= key_out_nxt_s;
            key_cnt_r  <= key_cnt_nxt_s;
            key_rise_r <= key_press_s;
        end
    end

`ifdef KEY_TOGGLE_EN
    logic key_toggle_r;

    // The operation-select bit flips on the same edge that raises key_rise.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            key_toggle_r <= 1'b0;
        end else begin
            key_toggle_r <= key_toggle_r ^ key_press_s;
        end
    end

    assign in_port2 = key_toggle_r;
`else
    assign in_port2 = key_out_r;
`endif

    assign in_port0 = sw0_out_r;
    assign in_port1 = sw1_out_r;
    assign key_rise = key_rise_r;

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed testbench for io_input_debounce with DEBOUNCE_CYCLES = 4.
// A raw value is applied just after a sampling point, so the next rising edge is
// "edge 0" of that change. The expected output update falls on the 6th
// step() after that point, which is edge 5.
module tb_io_input_debounce;

    logic       io_clk;
    logic       reset;
    logic [3:0] sw0_raw;
    logic [3:0] sw1_raw;
    logic       key_raw;
    logic [3:0] in_port0;
    logic [3:0] in_port1;
    logic       in_port2;
    logic       key_rise;

    int checks;
    int errors;

    io_input_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .io_clk  (io_clk),
        .reset   (reset),
        .sw0_raw (sw0_raw),
        .sw1_raw (sw1_raw),
        .key_raw (key_raw),
        .in_port0(in_port0),
        .in_port1(in_port1),
        .in_port2(in_port2),
        .key_rise(key_rise)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    task automatic step();
        @(posedge io_clk);
        #1;
    endtask

    task automatic do_reset();
        sw0_raw = 4'h0;
        sw1_raw = 4'h0;
        key_raw = 1'b0;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp4;
        logic       exp1;
        reset   = 1'b1;
        sw0_raw = 4'hF;
        sw1_raw = 4'hF;
        key_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({in_port0, in_port1, in_port2, key_rise} !== 10'h000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %h exp 000", i,
                         {in_port0, in_port1, in_port2, key_rise});
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp4 = (i >= 6) ? 4'hF : 4'h0;
            exp1 = (i >= 6) ? 1'b1 : 1'b0;
            checks++;
            if (in_port0 !== exp4) begin
                errors++;
                $display("FAIL reset_rel_p0 step %0d got %h exp %h", i, in_port0, exp4);
            end
            checks++;
            if (in_port1 !== exp4) begin
                errors++;
                $display("FAIL reset_rel_p1 step %0d got %h exp %h", i, in_port1, exp4);
            end
            checks++;
            if (in_port2 !== exp1) begin
                errors++;
                $display("FAIL reset_rel_p2 step %0d got %b exp %b", i, in_port2, exp1);
            end
            checks++;
            if (key_rise !== (i == 6)) begin
                errors++;
                $display("FAIL reset_rel_rise step %0d got %b exp %b", i, key_rise, (i == 6));
            end
        end
    endtask

    task automatic test_sw0_latency();
        logic [3:0] exp4;
        do_reset();
        sw0_raw = 4'hA;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp4 = (i >= 6) ? 4'hA : 4'h0;
            checks++;
            if (in_port0 !== exp4) begin
                errors++;
                $display("FAIL sw0_lat step %0d got %h exp %h", i, in_port0, exp4);
            end
            checks++;
            if ({in_port1, in_port2, key_rise} !== 6'h00) begin
                errors++;
                $display("FAIL sw0_isolation step %0d got %h exp 00", i,
                         {in_port1, in_port2, key_rise});
            end
        end
    endtask

    task automatic test_sw1_bounce();
        logic [3:0] exp4;
        do_reset();
        for (int b = 0; b < 3; b++) begin
            sw1_raw = (b == 1) ? 4'h0 : 4'h3;
            if (b < 2) begin
                for (int j = 0; j < 2; j++) begin
                    step();
                    checks++;
                    if (in_port1 !== 4'h0) begin
                        errors++;
                        $display("FAIL sw1_bounce phase %0d got %h exp 0", b, in_port1);
                    end
                end
            end
        end
        for (int i = 1; i <= 7; i++) begin
            step();
            exp4 = (i >= 6) ? 4'h3 : 4'h0;
            checks++;
            if (in_port1 !== exp4) begin
                errors++;
                $display("FAIL sw1_settle step %0d got %h exp %h", i, in_port1, exp4);
            end
            checks++;
            if (in_port0 !== 4'h0) begin
                errors++;
                $display("FAIL sw1_isolation step %0d got %h exp 0", i, in_port0);
            end
        end
    endtask

    task automatic test_key();
        logic exp1;
        do_reset();
        key_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            key_raw = 1'b0;
            checks++;
            if ({in_port2, key_rise} !== 2'b00) begin
                errors++;
                $display("FAIL key_glitch step %0d got %b exp 00", i, {in_port2, key_rise});
            end
        end
        key_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp1 = (i >= 6) ? 1'b1 : 1'b0;
            checks++;
            if (in_port2 !== exp1) begin
                errors++;
                $display("FAIL key_press_level step %0d got %b exp %b", i, in_port2, exp1);
            end
            checks++;
            if (key_rise !== (i == 6)) begin
                errors++;
                $display("FAIL key_press_rise step %0d got %b exp %b", i, key_rise, (i == 6));
            end
        end
        key_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
`ifdef KEY_TOGGLE_EN
            exp1 = 1'b1;
`else
            exp1 = (i >= 6) ? 1'b0 : 1'b1;
`endif
            checks++;
            if (in_port2 !== exp1) begin
                errors++;
                $display("FAIL key_release_level step %0d got %b exp %b", i, in_port2, exp1);
            end
            checks++;
            if (key_rise !== 1'b0) begin
                errors++;
                $display("FAIL key_release_rise step %0d got %b exp 0", i, key_rise);
            end
        end
    endtask

`ifdef KEY_TOGGLE_EN
    task automatic test_toggle();
        logic exp1;
        do_reset();
        exp1 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            key_raw = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                step();
                if (i == 6) exp1 = ~exp1;
                checks++;
                if ({in_port2, key_rise} !== {exp1, (i == 6)}) begin
                    errors++;
                    $display("FAIL toggle_press p%0d step %0d got %b exp %b", p, i,
                             {in_port2, key_rise}, {exp1, (i == 6)});
                end
            end
            key_raw = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                step();
                checks++;
                if ({in_port2, key_rise} !== {exp1, 1'b0}) begin
                    errors++;
                    $display("FAIL toggle_release p%0d step %0d got %b exp %b", p, i,
                             {in_port2, key_rise}, {exp1, 1'b0});
                end
            end
        end
    endtask
`endif

    task automatic test_reset_midcount();
        logic [3:0] exp4;
        do_reset();
        sw0_raw = 4'h5;
        for (int i = 1; i <= 4; i++) begin
            step();
        end
        reset = 1'b1;
        step();
        step();
        checks++;
        if (in_port0 !== 4'h0) begin
            errors++;
            $display("FAIL midcount_in_reset got %h exp 0", in_port0);
        end
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp4 = (i >= 6) ? 4'h5 : 4'h0;
            checks++;
            if (in_port0 !== exp4) begin
                errors++;
                $display("FAIL midcount_relatency step %0d got %h exp %h", i, in_port0, exp4);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        sw0_raw = 4'h0;
        sw1_raw = 4'h0;
        key_raw = 1'b0;
        test_reset();
        test_sw0_latency();
        test_sw1_bounce();
        test_key();
`ifdef KEY_TOGGLE_EN
        test_toggle();
`endif
        test_reset_midcount();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
